// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with a 2-entry {PC, inst} buffer and squashable request.
// Define IF_FETCH_PERF_EN to add saturating StallCount/BubbleCount outputs.

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] HALT_INST = 32'h00000073
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_in,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_if,
   output logic [31:0] Inst_if,
   output logic        valid_if,
   output logic        halt_if,
   output logic        Halted
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] StallCount,
   output logic [31:0] BubbleCount
`endif
);

   logic [31:0] fetch_pc;
   logic        req;
   logic [31:0] addr;
   logic [31:0] buf_pc   [2];
   logic [31:0] buf_inst [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  cnt;
   logic        squash;
   logic        stop;
   logic        halted;

   logic        done;
   logic        push;
   logic        pop;
   logic        head_halt;
   logic        halt_pop;
   logic        push_halt;
   logic        busy;
   logic [1:0]  cnt_nxt;
   logic        issue;

   assign valid_if  = (cnt != 2'd0);
   assign PC_if     = valid_if ? buf_pc[rd_ptr] : 32'd0;
   assign Inst_if   = valid_if ? buf_inst[rd_ptr] : 32'd0;
   assign halt_if   = head_halt;
   assign Halted    = halted;
   assign imem_req  = req;
   assign imem_addr = addr;

   // Handshake decode: push/pop, halt detection and next-request decision
   always_comb begin
      done      = req && imem_ack;
      head_halt = valid_if && (buf_inst[rd_ptr] == HALT_INST);
      push      = done && !squash && !Redirect;
      pop       = valid_if && !Stall_in && !Redirect;
      halt_pop  = pop && head_halt;
      push_halt = push && (imem_rdata == HALT_INST);
      busy      = req && !imem_ack;
      cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};
      issue     = !Redirect && !busy && !halt_pop && !halted
                  && !stop && !push_halt && (cnt_nxt < 2'd2);
   end

   // Request, buffer and control-flag state; redirect overrides everything
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fetch_pc <= RESET_PC;
         req      <= 1'b0;
         addr     <= 32'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         cnt      <= 2'd0;
         squash   <= 1'b0;
         stop     <= 1'b0;
         halted   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_pc[i]   <= 32'd0;
            buf_inst[i] <= 32'd0;
         end
      end else begin
         if (done) req <= 1'b0;
         if (issue) begin
            req      <= 1'b1;
            addr     <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (Redirect) begin
            cnt      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fetch_pc <= RedirectPC & ~32'd3;
            stop     <= 1'b0;
            halted   <= 1'b0;
            squash   <= busy;
         end else begin
            if (done) squash <= 1'b0;
            if (push) begin
               buf_pc[wr_ptr]   <= addr;
               buf_inst[wr_ptr] <= imem_rdata;
               wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt_nxt;
            if (push_halt) stop <= 1'b1;
            if (halt_pop) begin
               halted <= 1'b1;
               cnt    <= 2'd0;
               rd_ptr <= 1'b0;
               wr_ptr <= 1'b0;
            end
         end
      end
   end

`ifdef IF_FETCH_PERF_EN
   // Saturating stall and bubble counters
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         StallCount  <= 32'd0;
         BubbleCount <= 32'd0;
      end else begin
         if (valid_if && Stall_in && (StallCount != 32'hFFFFFFFF))
            StallCount <= StallCount + 32'd1;
         if (!valid_if && !halted && (BubbleCount != 32'hFFFFFFFF))
            BubbleCount <= BubbleCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus against a queue-based fetch model.
// Perf counter ports are checked when IF_FETCH_PERF_EN is defined.

module tb_if_fetch_unit;

   localparam logic [31:0] RPC  = 32'h00000000;
   localparam logic [31:0] HALT = 32'h00000073;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Stall_in;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] PC_if;
   logic [31:0] Inst_if;
   logic        valid_if;
   logic        halt_if;
   logic        Halted;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] StallCount;
   logic [31:0] BubbleCount;
`endif

   logic        ack_en;
   logic [31:0] halt_addr = 32'h1;
   logic        chk_on = 1'b0;
   int          vectors = 0;
   int          errors = 0;

   if_fetch_unit #(.RESET_PC(RPC), .HALT_INST(HALT)) dut (
      .CLK(CLK), .RST(RST), .Stall_in(Stall_in), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_if(PC_if),
      .Inst_if(Inst_if), .valid_if(valid_if), .halt_if(halt_if),
      .Halted(Halted)
`ifdef IF_FETCH_PERF_EN
      , .StallCount(StallCount), .BubbleCount(BubbleCount)
`endif
   );

   always #5 CLK = ~CLK;

   assign imem_ack   = ack_en & imem_req;
   assign imem_rdata = (imem_addr == halt_addr) ? HALT
                       : (imem_addr ^ 32'hA5A50000);

   // model state
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   bit          m_req;
   logic [31:0] m_addr;
   logic [31:0] m_fpc;
   bit          m_sq;
   bit          m_stop;
   bit          m_halted;
   logic [31:0] m_sc;
   logic [31:0] m_bc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == halt_addr) ? HALT : (a ^ 32'hA5A50000);
   endfunction

   function automatic void cmp(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      q_pc.delete();
      q_inst.delete();
      m_req = 0;
      m_addr = 32'd0;
      m_fpc = RPC;
      m_sq = 0;
      m_stop = 0;
      m_halted = 0;
      m_sc = 32'd0;
      m_bc = 32'd0;
   endfunction

   function automatic void model_step(input bit a, input bit s, input bit r,
                                      input logic [31:0] rpc);
      bit          ackd;
      bit          vld;
      logic [31:0] data;
      ackd = m_req && a;
      data = mem_word(m_addr);
      vld  = (q_pc.size() != 0);
      if (vld && s && m_sc != 32'hFFFFFFFF) m_sc++;
      if (!vld && !m_halted && m_bc != 32'hFFFFFFFF) m_bc++;
      if (r) begin
         q_pc.delete();
         q_inst.delete();
         m_fpc = rpc & 32'hFFFFFFFC;
         m_stop = 0;
         m_halted = 0;
         if (ackd) m_req = 0;
         m_sq = m_req;
         return;
      end
      if (vld && !s) begin
         if (q_inst[0] == HALT) begin
            m_halted = 1;
            q_pc.delete();
            q_inst.delete();
         end else begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
         end
      end
      if (ackd) begin
         m_req = 0;
         if (m_sq) m_sq = 0;
         else begin
            q_pc.push_back(m_addr);
            q_inst.push_back(data);
            if (data == HALT) m_stop = 1;
         end
      end
      if (!m_req && q_pc.size() < 2 && !m_stop && !m_halted) begin
         m_req = 1;
         m_addr = m_fpc;
         m_fpc = m_fpc + 32'd4;
      end
   endfunction

   // per-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_on) begin
         cmp("imem_req", 32'(imem_req), 32'(m_req));
         if (m_req) cmp("imem_addr", imem_addr, m_addr);
         cmp("valid_if", 32'(valid_if), 32'(q_pc.size() != 0));
         cmp("PC_if", PC_if, (q_pc.size() != 0) ? q_pc[0] : 32'd0);
         cmp("Inst_if", Inst_if, (q_inst.size() != 0) ? q_inst[0] : 32'd0);
         cmp("halt_if", 32'(halt_if),
             32'((q_inst.size() != 0) && (q_inst[0] == HALT)));
         cmp("Halted", 32'(Halted), 32'(m_halted));
`ifdef IF_FETCH_PERF_EN
         cmp("StallCount", StallCount, m_sc);
         cmp("BubbleCount", BubbleCount, m_bc);
`endif
      end
   end

   task automatic tick(input bit a, input bit s, input bit r,
                       input logic [31:0] rpc = 32'd0);
      ack_en = a;
      Stall_in = s;
      Redirect = r;
      RedirectPC = rpc;
      @(posedge CLK);
      model_step(a, s, r, rpc);
      #1;
   endtask

   task automatic reset_dut();
      #2;
      RST = 1'b0;
      ack_en = 1'b1;
      Redirect = 1'b0;
      model_reset();
      #1;
      cmp("rst_req", 32'(imem_req), 32'd0);
      cmp("rst_valid", 32'(valid_if), 32'd0);
      cmp("rst_pc", PC_if, 32'd0);
      cmp("rst_inst", Inst_if, 32'd0);
      cmp("rst_halt", 32'(halt_if), 32'd0);
      cmp("rst_halted", 32'(Halted), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   initial begin
      RST = 1'b0;
      Stall_in = 1'b0;
      Redirect = 1'b0;
      RedirectPC = 32'd0;
      ack_en = 1'b0;
      model_reset();
      chk_on = 1'b1;
      reset_dut();

      // streaming
      tick(1, 0, 0);
      cmp("seq_addr0", imem_addr, 32'h0);
      tick(1, 0, 0);
      cmp("seq_pc0", PC_if, 32'h0);
      cmp("seq_addr4", imem_addr, 32'h4);
      tick(1, 0, 0);
      cmp("seq_pc4", PC_if, 32'h4);

      // stall fills the buffer
      repeat (3) tick(1, 1, 0);
      cmp("stall_req", 32'(imem_req), 32'd0);
      cmp("stall_pc", PC_if, 32'h4);
      tick(1, 0, 0);
      cmp("unstall_pc8", PC_if, 32'h8);
      cmp("unstall_addr", imem_addr, 32'hC);
      tick(1, 0, 0);
      cmp("unstall_pc12", PC_if, 32'hC);
      repeat (4) tick(1, 0, 0);

      // redirect with outstanding request
      reset_dut();
      tick(0, 0, 1, 32'h10);
      tick(0, 0, 0);
      cmp("sq_addr10", imem_addr, 32'h10);
      tick(0, 0, 1, 32'h103);
      cmp("sq_hold", imem_addr, 32'h10);
      cmp("sq_hold_req", 32'(imem_req), 32'd1);
      tick(0, 0, 0);
      tick(1, 0, 0);
      cmp("sq_drop", 32'(valid_if), 32'd0);
      cmp("sq_newaddr", imem_addr, 32'h100);
      tick(1, 0, 0);
      cmp("sq_pc100", PC_if, 32'h100);
      tick(0, 0, 1, 32'h300);
      tick(0, 0, 1, 32'h500);
      tick(1, 0, 0);
      cmp("sq2_addr", imem_addr, 32'h500);
      cmp("sq2_valid", 32'(valid_if), 32'd0);
      tick(1, 0, 0);
      cmp("sq2_pc", PC_if, 32'h500);

      // halt
      halt_addr = 32'h8;
      reset_dut();
      repeat (4) tick(1, 0, 0);
      cmp("halt_head", 32'(halt_if), 32'd1);
      cmp("halt_pc", PC_if, 32'h8);
      cmp("halt_noreq", 32'(imem_req), 32'd0);
      tick(1, 0, 0);
      cmp("halted", 32'(Halted), 32'd1);
      cmp("halted_valid", 32'(valid_if), 32'd0);
      tick(1, 0, 0);
      cmp("halted_noreq", 32'(imem_req), 32'd0);
      tick(0, 0, 1, 32'h40);
      cmp("unhalt", 32'(Halted), 32'd0);
      tick(1, 0, 0);
      cmp("resume_addr", imem_addr, 32'h40);
      halt_addr = 32'h1;

      // reset in the middle of a request
      reset_dut();
      tick(1, 1, 0);
      tick(1, 1, 0);
      tick(0, 1, 0);
      reset_dut();
      tick(1, 0, 0);
      cmp("rst_first", imem_addr, RPC);

      // wrap-around and misaligned redirect
      tick(1, 0, 1, 32'hFFFFFFFF);
      tick(1, 0, 0);
      tick(1, 0, 0);
      cmp("wrap_addr", imem_addr, 32'h0);
      cmp("wrap_pc", PC_if, 32'hFFFFFFFC);

      // mixed traffic
      for (int i = 0; i < 24; i++)
         tick(i % 3 != 0, i % 4 == 1, i == 7 || i == 12,
              32'h200 + 32'(i) * 32'd16);
      repeat (6) tick(1, 0, 0);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
